mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the CPU's single-port instruction/data memory between the fetch path and the load/store path of the multi-cycle core.
- Accepts one access at a time, sequences it to the memory with a ready handshake, and returns read data or a write acknowledgement to the winning requester.
- Sits between the control unit/datapath and the memory array; the data port has priority, with a starvation guard for fetch.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- STARVE_MAX, 4, consecutive lost arbitrations after which fetch wins; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  AW  fetch address.
- if_gnt  out  1  one-cycle fetch grant pulse.
- if_done  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DW  fetched instruction.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_gnt  out  1  one-cycle data grant pulse.
- d_done  out  1  one-cycle pulse; load data valid, or store complete.
- d_rdata  out  DW  load data.
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completes the access this cycle.

Behaviour:
- Reset (async, rst_n = 0): state IDLE; starve_cnt = 0; all outputs 0, including rdata registers.
  - Any in-flight access is dropped with no done pulse.
  - Memory must tolerate mem_en dropping mid-access.
- States and transitions:
  - IDLE: req inputs are sampled only in IDLE.
  - IDLE -> BUSY_D when the data port wins; IDLE -> BUSY_F when fetch wins.
  - BUSY_D / BUSY_F -> IDLE at the edge where mem_ready = 1 is sampled.
  - mem_ready in IDLE is ignored.
- Arbitration at the edge leaving IDLE:
  - d_req only -> data wins.
  - if_req only -> fetch wins.
  - Both requests -> data wins, unless starve_cnt == STARVE_MAX, in which case fetch wins.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) when both requests are present and data wins.
  - Clears to 0 whenever fetch is granted.
  - Unchanged otherwise.
- Grant edge: all outputs are registered. In the first BUSY cycle:
  - gnt of the winner = 1 for exactly one cycle.
  - mem_en = 1.
  - mem_addr / mem_we / mem_wdata latch the winner's inputs. For fetch, mem_we = 0 and mem_wdata = 0.
  - The latched values hold stable through the whole BUSY state, regardless of requester inputs.
- Completion edge (mem_ready = 1 sampled in BUSY):
  - mem_en, mem_we -> 0 and state -> IDLE.
  - done of the owner = 1 for one cycle.
  - On reads, the rdata register captures mem_rdata. On stores, d_rdata holds its previous value.
- Latency:
  - req sampled at edge E0 -> gnt and mem_en high after E0.
  - mem_ready high in the first BUSY cycle -> done after edge E1 = E0 + 1 clk.
  - Minimum is 2 cycles from request to done; each wait cycle of mem_ready adds 1.
- Back-to-back: the done cycle is an IDLE cycle, so a req still high there starts a new access. A requester wanting one access drops req after gnt.
- Withdrawal: req deasserted before gnt is legal and causes no access.
- At most one done and one gnt are asserted in any cycle; if_gnt and d_gnt are never both high.

Decomposition:
- Shared package/header mem_arb_defs:
  - state encodings IDLE = 2'd0, BUSY_F = 2'd1, BUSY_D = 2'd2;
  - AW/DW defaults, shared with the CU and memory.
- One natural sub-module: arb_starve_cnt, the saturating starvation counter with clear. The remainder is a single FSM with registered outputs.

Test Plan:
- Single load: d_req = 1, d_we = 0, d_addr = 0x40; mem_ready high the first BUSY cycle with mem_rdata = 0xDEADBEEF -> d_gnt 1 cycle after request, mem_addr = 0x40, d_done the next cycle with d_rdata = 0xDEADBEEF, mem_en low after.
- Store with wait states: d_we = 1, d_addr = 0x80, d_wdata = 0x12345678, mem_ready delayed 3 cycles -> mem_en/mem_we/mem_addr/mem_wdata stable for 4 cycles while requester inputs are changed, then d_done; d_rdata unchanged.
- Simultaneous requests: if_req and d_req held continuously with STARVE_MAX = 4 -> grant order D, D, D, D, F, D, ... with starve_cnt clearing after the F grant; never both gnts in one cycle.
- Fetch alone: if_addr = 0x0, mem_rdata = 0x00500093 -> if_done with if_rdata = 0x00500093, mem_we = 0 throughout.
- Reset mid-access: assert rst_n = 0 during BUSY_D -> all outputs 0 immediately (asynchronously), no d_done; after release, a new if_req is served normally.
- Withdrawal and stray ready: d_req pulsed low before sampling plus mem_ready = 1 in IDLE -> no gnt, no done, no state change.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter: widths, FSM encoding
// and the latched memory command.
package mem_port_arbiter_pkg;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory port of the arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = mem_port_arbiter_pkg::AW,
  parameter int unsigned DW = mem_port_arbiter_pkg::DW
);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_done;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_done;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requesters plus memory side.
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_starve_cnt.sv
// Saturating count of arbitrations fetch has lost to the data port; at_max_o
// tells the arbiter that fetch must win the next contested arbitration.
module mem_port_arbiter_starve_cnt
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_max_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_W'(STARVE_MAX))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // at_max is registered alongside the count so it is valid at the next arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      at_max_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      at_max_q <= (cnt_d == CNT_W'(STARVE_MAX));
    end
  end

  assign at_max_o = at_max_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store. Data port
// has priority; fetch wins a contested arbitration once it has lost STARVE_MAX times.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   arb
);

  arb_state_e    state_q;
  mem_cmd_t      cmd_q;
  logic          mem_en_q;
  logic          if_gnt_q, d_gnt_q;
  logic          if_done_q, d_done_q;
  logic [DW-1:0] if_rdata_q, d_rdata_q;

  logic in_idle, f_win, d_win;
  logic starve_inc, starve_clr, starve_at_max;

  // Requests only matter in IDLE; contested arbitration goes to data unless fetch is starved.
  assign in_idle    = (state_q == IDLE);
  assign f_win      = in_idle & arb.if_req & (~arb.d_req | starve_at_max);
  assign d_win      = in_idle & arb.d_req & ~f_win;
  assign starve_inc = d_win & arb.if_req;
  assign starve_clr = f_win;

  mem_port_arbiter_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_i    (starve_inc),
    .clr_i    (starve_clr),
    .at_max_o (starve_at_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      mem_en_q   <= 1'b0;
      if_gnt_q   <= 1'b0;
      d_gnt_q    <= 1'b0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if_gnt_q  <= 1'b0;
      d_gnt_q   <= 1'b0;
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (d_win) begin
            state_q  <= BUSY_D;
            d_gnt_q  <= 1'b1;
            mem_en_q <= 1'b1;
            cmd_q    <= '{we: arb.d_we, addr: arb.d_addr, wdata: arb.d_wdata};
          end else if (f_win) begin
            state_q  <= BUSY_F;
            if_gnt_q <= 1'b1;
            mem_en_q <= 1'b1;
            cmd_q    <= '{we: 1'b0, addr: arb.if_addr, wdata: '0};
          end
        end
        BUSY_F, BUSY_D: begin
          // Command stays latched until the memory signals completion.
          if (arb.mem_ready) begin
            state_q  <= IDLE;
            mem_en_q <= 1'b0;
            cmd_q.we <= 1'b0;
            if (state_q == BUSY_F) begin
              if_done_q  <= 1'b1;
              if_rdata_q <= arb.mem_rdata;
            end else begin
              d_done_q <= 1'b1;
              if (!cmd_q.we) begin
                d_rdata_q <= arb.mem_rdata;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arb.if_gnt    = if_gnt_q;
  assign arb.if_done   = if_done_q;
  assign arb.if_rdata  = if_rdata_q;
  assign arb.d_gnt     = d_gnt_q;
  assign arb.d_done    = d_done_q;
  assign arb.d_rdata   = d_rdata_q;
  assign arb.mem_en    = mem_en_q;
  assign arb.mem_we    = cmd_q.we;
  assign arb.mem_addr  = cmd_q.addr;
  assign arb.mem_wdata = cmd_q.wdata;

endmodule
